// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int REG_ADDR_W = 4;
  localparam int WAIT_CNT_W = 16;

  function automatic logic src_hit(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] dest,
    input logic                  wb_en
  );
    return wb_en && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle: decode/exe/mem operand info in, stage freeze/flush controls out.
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  two_src;
  logic                  src_valid;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic                  exe_mem_r_en;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  fwd_en;
  logic                  branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  freeze_pc;
  logic                  freeze_if;
  logic                  flush_if;
  logic                  freeze_id;
  logic                  flush_id;
  logic                  stall_pipe;
  logic                  mem_wait;

  modport master (
    output src1, src2, two_src, src_valid, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
    input  freeze_pc, freeze_if, flush_if, freeze_id, flush_id, stall_pipe, mem_wait
  );

  modport slave (
    input  src1, src2, two_src, src_valid, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
    output freeze_pc, freeze_if, flush_if, freeze_id, flush_id, stall_pipe, mem_wait
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // count register, sticks at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Drives IF/ID freeze/flush and EXE/MEM stall from data hazards, taken branches
// and the data-memory handshake; keeps stall/bubble counters and a timeout flag.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  hazard_stall_ctrl_if.slave pipe,
  input  logic             cnt_clr,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT_M1 = WAIT_CNT_W'(WAIT_MAX - 1);

  state_e                state_r;
  state_e                state_nxt_s;
  logic [WAIT_CNT_W-1:0] wait_cnt_r;
  logic                  timeout_r;
  logic                  mem_stall_s;
  logic                  exe_hit_s;
  logic                  mem_hit_s;
  logic                  hazard_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: enter wait on an unaccepted request, leave on ready
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (pipe.mem_req && !pipe.mem_ready) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (pipe.mem_ready) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // operand hazard detection; with forwarding only a load in EXE needs a bubble
  always_comb begin
    exe_hit_s = src_hit(pipe.src1, pipe.exe_dest, pipe.exe_wb_en) ||
                (pipe.two_src && src_hit(pipe.src2, pipe.exe_dest, pipe.exe_wb_en));
    mem_hit_s = src_hit(pipe.src1, pipe.mem_dest, pipe.mem_wb_en) ||
                (pipe.two_src && src_hit(pipe.src2, pipe.mem_dest, pipe.mem_wb_en));
    if (!pipe.src_valid) begin
      hazard_s = 1'b0;
    end else if (pipe.fwd_en) begin
      hazard_s = exe_hit_s && pipe.exe_mem_r_en;
    end else begin
      hazard_s = exe_hit_s || mem_hit_s;
    end
  end

  assign mem_stall_s = (state_r == MEM_WAIT) || (pipe.mem_req && !pipe.mem_ready);

  // FSM outputs: memory stall beats branch flush beats data-hazard bubble
  always_comb begin
    pipe.freeze_pc  = 1'b0;
    pipe.freeze_if  = 1'b0;
    pipe.flush_if   = 1'b0;
    pipe.freeze_id  = 1'b0;
    pipe.flush_id   = 1'b0;
    pipe.stall_pipe = 1'b0;
    pipe.mem_wait   = (state_r == MEM_WAIT);
    if (mem_stall_s) begin
      pipe.freeze_pc  = 1'b1;
      pipe.freeze_if  = 1'b1;
      pipe.freeze_id  = 1'b1;
      pipe.stall_pipe = 1'b1;
    end else if (pipe.branch_taken) begin
      pipe.flush_if = 1'b1;
      pipe.flush_id = 1'b1;
    end else if (hazard_s) begin
      pipe.freeze_pc = 1'b1;
      pipe.freeze_if = 1'b1;
      pipe.flush_id  = 1'b1;
    end else begin
      pipe.freeze_pc = 1'b0;
    end
  end

  // wait length tracking; the timeout flag is sticky and never aborts the wait
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= {WAIT_CNT_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      if (state_r == RUN) begin
        wait_cnt_r <= {WAIT_CNT_W{1'b0}};
      end else if (!pipe.mem_ready && (wait_cnt_r != {WAIT_CNT_W{1'b1}})) begin
        wait_cnt_r <= wait_cnt_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
      end
      if ((state_r == MEM_WAIT) && !pipe.mem_ready && (wait_cnt_r >= WAIT_LIMIT_M1)) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pipe.freeze_pc),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pipe.flush_id),
    .clr (cnt_clr),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int CNT_W    = 6;
  localparam int WAIT_MAX = 3;
  localparam int CAP      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cnt_clr;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe        (bus),
    .cnt_clr     (cnt_clr),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_wait;
  int m_waited;
  bit m_timeout;
  int m_stall;
  int m_bubble;

  // {freeze_pc, freeze_if, flush_if, freeze_id, flush_id, stall_pipe}
  function automatic logic [5:0] dut_ctrl();
    return {bus.freeze_pc, bus.freeze_if, bus.flush_if, bus.freeze_id, bus.flush_id, bus.stall_pipe};
  endfunction

  function automatic logic [5:0] model_ctrl();
    int srcs[$];
    bit in_exe;
    bit in_mem;
    bit hz;
    if (m_wait || (bus.mem_req && !bus.mem_ready)) return 6'b110101;
    if (bus.branch_taken) return 6'b001010;
    hz = 1'b0;
    if (bus.src_valid) begin
      srcs.push_back(int'(bus.src1));
      if (bus.two_src) srcs.push_back(int'(bus.src2));
      foreach (srcs[i]) begin
        in_exe = bus.exe_wb_en && (int'(bus.exe_dest) == srcs[i]);
        in_mem = bus.mem_wb_en && (int'(bus.mem_dest) == srcs[i]);
        if (bus.fwd_en) begin
          if (in_exe && bus.exe_mem_r_en) hz = 1'b1;
        end else if (in_exe || in_mem) begin
          hz = 1'b1;
        end
      end
    end
    return hz ? 6'b110010 : 6'b000000;
  endfunction

  task automatic model_reset();
    m_wait = 1'b0; m_waited = 0; m_timeout = 1'b0; m_stall = 0; m_bubble = 0;
  endtask

  task automatic model_edge();
    logic [5:0] c;
    c = model_ctrl();
    if (cnt_clr) begin
      m_stall = 0; m_bubble = 0;
    end else begin
      if (c[5] && m_stall < CAP) m_stall++;
      if (c[1] && m_bubble < CAP) m_bubble++;
    end
    if (m_wait) begin
      if (bus.mem_ready) begin
        m_wait = 1'b0;
      end else begin
        m_waited++;
        if (m_waited >= WAIT_MAX) m_timeout = 1'b1;
      end
    end else if (bus.mem_req && !bus.mem_ready) begin
      m_wait = 1'b1; m_waited = 0;
    end
  endtask

  task automatic step_cycle();
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.src1 = 4'd0; bus.src2 = 4'd0; bus.two_src = 1'b0; bus.src_valid = 1'b0;
    bus.exe_dest = 4'd0; bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0;
    bus.mem_dest = 4'd0; bus.mem_wb_en = 1'b0; bus.fwd_en = 1'b0;
    bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (dut_ctrl() !== 6'b000000) begin bad++; $display("FAIL reset_ctrl: got %b want 000000", dut_ctrl()); end
    total++; if (bus.mem_wait !== 1'b0) begin bad++; $display("FAIL reset_mem_wait: got %b want 0", bus.mem_wait); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
    total++; if (stall_cnt !== 6'd0) begin bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    total++; if (bubble_cnt !== 6'd0) begin bad++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_hazard_nofwd();
    clear_inputs();
    bus.src_valid = 1'b1; bus.src1 = 4'd3; bus.exe_dest = 4'd3; bus.exe_wb_en = 1'b1;
    #1;
    total++; if (dut_ctrl() !== 6'b110010) begin bad++; $display("FAIL nofwd_exe: got %b want 110010", dut_ctrl()); end
    step_cycle();
    total++; if (bubble_cnt !== 6'd1) begin bad++; $display("FAIL nofwd_bubble_cnt: got %0d want 1", bubble_cnt); end
    total++; if (stall_cnt !== 6'd1) begin bad++; $display("FAIL nofwd_stall_cnt: got %0d want 1", stall_cnt); end
    bus.exe_wb_en = 1'b0; bus.mem_dest = 4'd3; bus.mem_wb_en = 1'b1;
    #1;
    total++; if (dut_ctrl() !== 6'b110010) begin bad++; $display("FAIL nofwd_mem: got %b want 110010", dut_ctrl()); end
    bus.fwd_en = 1'b1;
    #1;
    total++; if (dut_ctrl() !== 6'b000000) begin bad++; $display("FAIL fwd_mem_only: got %b want 000000", dut_ctrl()); end
    bus.fwd_en = 1'b0; bus.src_valid = 1'b0;
    #1;
    total++; if (dut_ctrl() !== 6'b000000) begin bad++; $display("FAIL bubble_in_id: got %b want 000000", dut_ctrl()); end
    step_cycle();
  endtask

  task automatic test_fwd();
    clear_inputs();
    bus.src_valid = 1'b1; bus.fwd_en = 1'b1; bus.src1 = 4'd3; bus.exe_dest = 4'd3; bus.exe_wb_en = 1'b1;
    #1;
    total++; if (dut_ctrl() !== 6'b000000) begin bad++; $display("FAIL fwd_alu: got %b want 000000", dut_ctrl()); end
    bus.exe_mem_r_en = 1'b1;
    #1;
    total++; if (dut_ctrl() !== 6'b110010) begin bad++; $display("FAIL fwd_load: got %b want 110010", dut_ctrl()); end
    bus.src1 = 4'd5; bus.src2 = 4'd3; bus.two_src = 1'b0;
    #1;
    total++; if (dut_ctrl() !== 6'b000000) begin bad++; $display("FAIL fwd_src2_unused: got %b want 000000", dut_ctrl()); end
    bus.two_src = 1'b1;
    #1;
    total++; if (dut_ctrl() !== 6'b110010) begin bad++; $display("FAIL fwd_src2_load: got %b want 110010", dut_ctrl()); end
    step_cycle();
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.src_valid = 1'b1; bus.src1 = 4'd9; bus.exe_dest = 4'd9; bus.exe_wb_en = 1'b1; bus.branch_taken = 1'b1;
    #1;
    total++; if (dut_ctrl() !== 6'b001010) begin bad++; $display("FAIL branch_over_hazard: got %b want 001010", dut_ctrl()); end
    step_cycle();
    total++; if (bubble_cnt !== CNT_W'(m_bubble)) begin bad++; $display("FAIL branch_bubble_cnt: got %0d want %0d", bubble_cnt, m_bubble); end
  endtask

  task automatic test_mem_wait();
    int n_freeze;
    int n_stall;
    int n_wait;
    int n_flush;
    n_freeze = 0; n_stall = 0; n_wait = 0; n_flush = 0;
    clear_inputs();
    cnt_clr = 1'b1;
    step_cycle();
    cnt_clr = 1'b0;
    bus.mem_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.mem_ready = (k == 5);
      bus.branch_taken = (k >= 2 && k <= 4);
      #1;
      if (bus.freeze_pc && bus.freeze_if && bus.freeze_id) n_freeze++;
      if (bus.stall_pipe) n_stall++;
      if (bus.mem_wait) n_wait++;
      if (bus.flush_if || bus.flush_id) n_flush++;
      step_cycle();
    end
    clear_inputs();
    #1;
    total++; if (n_freeze !== 5) begin bad++; $display("FAIL wait_freeze_cycles: got %0d want 5", n_freeze); end
    total++; if (n_stall !== 5) begin bad++; $display("FAIL wait_stall_pipe_cycles: got %0d want 5", n_stall); end
    total++; if (n_wait !== 4) begin bad++; $display("FAIL wait_mem_wait_cycles: got %0d want 4", n_wait); end
    total++; if (n_flush !== 0) begin bad++; $display("FAIL wait_branch_flush: got %0d want 0", n_flush); end
    total++; if (bus.mem_wait !== 1'b0 || bus.freeze_pc !== 1'b0) begin bad++; $display("FAIL wait_back_to_run: got %b%b want 00", bus.mem_wait, bus.freeze_pc); end
    total++; if (stall_cnt !== 6'd5) begin bad++; $display("FAIL wait_stall_cnt: got %0d want 5", stall_cnt); end
    total++; if (bubble_cnt !== 6'd0) begin bad++; $display("FAIL wait_bubble_cnt: got %0d want 0", bubble_cnt); end
    step_cycle();
  endtask

  task automatic test_timeout();
    clear_inputs();
    rst = 1'b0; model_reset();
    #1;
    rst = 1'b1;
    #1;
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL to_after_reset: got %b want 0", mem_timeout); end
    bus.mem_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      bus.mem_ready = 1'b0;
      #1;
      total++; if (mem_timeout !== (k >= 5)) begin bad++; $display("FAIL to_rise k=%0d: got %b want %b", k, mem_timeout, (k >= 5)); end
      total++; if (bus.mem_wait !== (k >= 2)) begin bad++; $display("FAIL to_mem_wait k=%0d: got %b want %b", k, bus.mem_wait, (k >= 2)); end
      step_cycle();
    end
    bus.mem_ready = 1'b1;
    #1;
    total++; if (bus.stall_pipe !== 1'b1) begin bad++; $display("FAIL to_ready_cycle_stall: got %b want 1", bus.stall_pipe); end
    step_cycle();
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    #1;
    total++; if (bus.mem_wait !== 1'b0 || mem_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got wait=%b to=%b want wait=0 to=1", bus.mem_wait, mem_timeout); end
    step_cycle();
    // reset in the middle of a wait
    bus.mem_req = 1'b1;
    step_cycle();
    step_cycle();
    #1;
    total++; if (bus.mem_wait !== 1'b1) begin bad++; $display("FAIL midrst_pre_wait: got %b want 1", bus.mem_wait); end
    #2;
    rst = 1'b0; model_reset();
    #1;
    total++; if (bus.mem_wait !== 1'b0 || mem_timeout !== 1'b0 || stall_cnt !== 6'd0) begin
      bad++; $display("FAIL midrst_state: got wait=%b to=%b stall=%0d want 0 0 0", bus.mem_wait, mem_timeout, stall_cnt);
    end
    total++; if (bus.freeze_pc !== 1'b1) begin bad++; $display("FAIL midrst_follow_inputs: got %b want 1", bus.freeze_pc); end
    bus.mem_req = 1'b0;
    #1;
    total++; if (dut_ctrl() !== 6'b000000) begin bad++; $display("FAIL midrst_idle: got %b want 000000", dut_ctrl()); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    clear_inputs();
    cnt_clr = 1'b1;
    step_cycle();
    cnt_clr = 1'b0;
    bus.src_valid = 1'b1; bus.src1 = 4'd7; bus.exe_dest = 4'd7; bus.exe_wb_en = 1'b1;
    repeat (CAP + 5) step_cycle();
    #1;
    total++; if (stall_cnt !== CNT_W'(CAP)) begin bad++; $display("FAIL sat_stall: got %0d want %0d", stall_cnt, CAP); end
    total++; if (bubble_cnt !== CNT_W'(CAP)) begin bad++; $display("FAIL sat_bubble: got %0d want %0d", bubble_cnt, CAP); end
    cnt_clr = 1'b1;
    step_cycle();
    cnt_clr = 1'b0;
    #1;
    total++; if (stall_cnt !== 6'd0 || bubble_cnt !== 6'd0) begin bad++; $display("FAIL clr_priority: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
    step_cycle();
    total++; if (stall_cnt !== 6'd1) begin bad++; $display("FAIL count_after_clr: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_random(input int n, input int ready_pct);
    logic [5:0] exp;
    clear_inputs();
    rst = 1'b0; model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.src1 = 4'($urandom_range(0, 3));
      bus.src2 = 4'($urandom_range(0, 3));
      bus.exe_dest = 4'($urandom_range(0, 3));
      bus.mem_dest = 4'($urandom_range(0, 3));
      bus.two_src = 1'($urandom_range(0, 1));
      bus.src_valid = ($urandom_range(0, 7) != 0);
      bus.exe_wb_en = 1'($urandom_range(0, 1));
      bus.exe_mem_r_en = 1'($urandom_range(0, 1));
      bus.mem_wb_en = 1'($urandom_range(0, 1));
      bus.fwd_en = 1'($urandom_range(0, 1));
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.mem_req = ($urandom_range(0, 3) == 0);
      bus.mem_ready = ($urandom_range(0, 99) < ready_pct);
      cnt_clr = ($urandom_range(0, 49) == 0);
      #1;
      exp = model_ctrl();
      total++; if (dut_ctrl() !== exp) begin bad++; $display("FAIL rand_ctrl i=%0d: got %b want %b", i, dut_ctrl(), exp); end
      total++; if (bus.mem_wait !== m_wait) begin bad++; $display("FAIL rand_mem_wait i=%0d: got %b want %b", i, bus.mem_wait, m_wait); end
      total++; if (mem_timeout !== m_timeout) begin bad++; $display("FAIL rand_timeout i=%0d: got %b want %b", i, mem_timeout, m_timeout); end
      total++; if (stall_cnt !== CNT_W'(m_stall)) begin bad++; $display("FAIL rand_stall_cnt i=%0d: got %0d want %0d", i, stall_cnt, m_stall); end
      total++; if (bubble_cnt !== CNT_W'(m_bubble)) begin bad++; $display("FAIL rand_bubble_cnt i=%0d: got %0d want %0d", i, bubble_cnt, m_bubble); end
      step_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_hazard_nofwd();
    test_fwd();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random(400, 70);
    test_random(400, 30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
